es_ports: RTL and testbench
===========================

# es_ports

Parametrised I/O port unit for the single-cycle CPU: replaces fixed 4×8-bit input/output ports with N channels of W bits, CPU-side register access, input synchronisation, per-channel change detection with maskable interrupt, and an optional timed-pulse output mode. Sits between the CPU's I/O bus and the external `e`/`s` pins; the CPU and its testbench drive it with `clk` and `reset`.

## Interface
- `N`, 4: number of input and output channels (1..W)
- `W`, 8: channel data width in bits
- `PULSE`, 3: pulse-mode output hold length in cycles (≥1)
- `AW`, derived = clog2(N+3): address width
- `clk`  in  1  rising-edge clock, single clock domain
- `reset`  in  1  asynchronous, active-low reset (low = reset asserted)
- `addr`  in  AW  register address
- `we`  in  1  write strobe
- `re`  in  1  read strobe
- `wdata`  in  W  write data
- `rdata`  out  W  registered read data
- `e`  in  N*W  external inputs, channel i at bits [i*W +: W], asynchronous to `clk`
- `s`  out  N*W  output latches, channel i at bits [i*W +: W]
- `irq`  out  1  interrupt request, OR of (flag & mask)

## Operation
- Address map: 0..N-1 data channel i (read = synchronised input i, write = output latch i); N = STATUS (change flags, bits N-1:0); N+1 = MASK (irq enables); N+2 = MODE (bit i = 1 → channel i pulse mode). Bits ≥N read 0, writes ignored.
- Out-of-range address: write ignored, read returns 0.
- Input path per channel: sync1 ← e_i, sync2 ← sync1, prev ← sync2 each cycle. Flag_i set when sync2 ≠ prev. Flags sticky.
- Flag clear: read of channel i, or write to STATUS with wdata bit i = 1 (W1C). Set in same cycle as clear → flag stays set (set wins).
- Read of channel i returns sync2_i; read of STATUS returns pre-clear flags.
- Output write, level mode (MODE_i = 0): s_i ← wdata, held indefinitely.
- Output write, pulse mode (MODE_i = 1): s_i ← wdata, counter_i ← PULSE; counter decrements each cycle; on the cycle it reaches 0, s_i ← 0. Rewrite during pulse reloads s_i and counter. Writing 0 in pulse mode sets s_i = 0, counter still loaded (harmless).
- Clearing MODE_i mid-pulse: counter_i forced to 0, s_i keeps current value (becomes level).
- `we` and `re` may assert together on the same or different addresses; both take effect; read sees pre-write register state.
- `irq` = |(flags & MASK), combinational from registers, no glitches from inputs.
- Reset (async, `reset` low): s = 0, rdata = 0, flags = 0, MASK = 0, MODE = 0, counters = 0, sync/prev = 0, irq = 0. Reset mid-pulse aborts pulse. After release, first edge resumes normal operation; a nonzero e already present sets its flag 3 edges later (prev was 0).

## Timing
- Write: s_i updates on the edge where `we` is sampled.
- Read: `rdata` valid after the edge where `re` is sampled (1-cycle latency); holds value when `re` low.
- Input → rdata: change on e at/before edge k appears in sync2 after edge k+1; readable with `re` at edge k+2.
- Input → flag/irq: flag and irq rise after edge k+2.
- Pulse: write at edge t → s_i = wdata for edges t..t+PULSE-1, s_i = 0 after edge t+PULSE (PULSE cycles high).
- W1C/read-clear: flag drops after the edge sampling the access; irq falls same time.

## Test plan
- Reset: hold reset low, drive e = all 0x55 → s = 0, rdata = 0, irq = 0; release → flags all set 3 edges later, irq stays 0 (MASK = 0).
- Level output (N=4, W=8): write 0xA5 to addr 2 → s[23:16] = 0xA5 after that edge, other channels 0, stays for 20 cycles.
- Input + irq: MASK = 0x02, change e ch1 0x00→0x08 → irq high 3 edges later, read addr 1 → rdata = 0x08 next cycle, flag/irq clear; ch3 change 0x80 sets STATUS bit 3, irq stays 0.
- Set-wins: W1C STATUS = 0x01 on the edge ch0 flag sets → STATUS reads 0x01, irq remains if masked.
- Pulse (PULSE=3): MODE = 0x01, write 0x05 to addr 0 → s[7:0] = 0x05 for 3 cycles then 0x00; rewrite 0x0C at cycle 2 → 0x0C for 3 more cycles.
- Reset mid-pulse and out-of-range: assert reset during pulse → s = 0 immediately (async); write addr 7 (0x7 > N+2) → no state change, read addr 7 → 0x00.

Source files
------------

// File: rtl/es_ports.sv
// Parametrised CPU I/O port unit: N channels of W bits with synchronised inputs,
// sticky change flags feeding a maskable irq, and level or timed-pulse outputs.
module es_ports #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int PULSE = 3,
  localparam int AW   = $clog2(N + 3)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [AW-1:0]  addr,
  input  logic           we,
  input  logic           re,
  input  logic [W-1:0]   wdata,
  output logic [W-1:0]   rdata,
  input  logic [N*W-1:0] e,
  output logic [N*W-1:0] s,
  output logic           irq
);

  localparam int CW = $clog2(PULSE + 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE);

  logic [N*W-1:0]       sync1, sync2, prev;
  logic [N-1:0]         flags, mask, mode;
  logic [N-1:0][CW-1:0] cnt;
  logic [N-1:0]         set_f, clr_f, pulse_en;
  logic                 mode_wr;
  logic [W-1:0]         rd_val;

  assign irq     = |(flags & mask);
  assign mode_wr = we && (int'(addr) == N + 2);

  always_comb begin
    set_f    = '0;
    clr_f    = '0;
    pulse_en = '0;
    for (int i = 0; i < N; i++) begin
      set_f[i]    = sync2[i*W +: W] != prev[i*W +: W];
      clr_f[i]    = (re && int'(addr) == i) || (we && int'(addr) == N && wdata[i]);
      // A same-cycle MODE write decides whether a data write starts a pulse.
      pulse_en[i] = mode_wr ? wdata[i] : mode[i];
    end
  end

  always_comb begin
    rd_val = '0;
    if (int'(addr) < N)
      rd_val = sync2[int'(addr)*W +: W];
    else if (int'(addr) == N)
      rd_val[N-1:0] = flags;
    else if (int'(addr) == N + 1)
      rd_val[N-1:0] = mask;
    else if (int'(addr) == N + 2)
      rd_val[N-1:0] = mode;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      flags <= '0;
      mask  <= '0;
      mode  <= '0;
      cnt   <= '0;
      s     <= '0;
      rdata <= '0;
    end else begin
      sync1 <= e;
      sync2 <= sync1;
      prev  <= sync2;
      // Set wins over a clear arriving on the same edge.
      flags <= (flags & ~clr_f) | set_f;
      if (re)
        rdata <= rd_val;
      if (we && int'(addr) == N + 1)
        mask <= wdata[N-1:0];
      if (mode_wr)
        mode <= wdata[N-1:0];
      for (int i = 0; i < N; i++) begin
        if (we && int'(addr) == i) begin
          s[i*W +: W] <= wdata;
          cnt[i]      <= pulse_en[i] ? PULSE_LD : '0;
        end else if (mode_wr && !wdata[i]) begin
          cnt[i] <= '0;
        end else if (mode[i] && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
          if (cnt[i] == CW'(1))
            s[i*W +: W] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_es_ports.sv
// Directed bench for es_ports: reads push expected data into a queue that a
// monitor drains one cycle later; pin-level outputs are checked inline.
module tb_es_ports;

  localparam int N = 4;
  localparam int W = 8;
  localparam int AW = $clog2(N + 3);

  logic          clk;
  logic          reset;
  logic [AW-1:0] addr;
  logic          we, re;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata;
  logic [N*W-1:0] e;
  logic [N*W-1:0] s;
  logic          irq;

  logic [W-1:0] exp_q[$];
  logic         rd_pend;
  int           n_vec;
  int           n_err;

  es_ports #(.N(N), .W(W), .PULSE(3)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .re(re),
    .wdata(wdata), .rdata(rdata), .e(e), .s(s), .irq(irq)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: act=0x%0h req=0x%0h", name, act, req);
    end
  endtask

  // monitor: rdata is presented one cycle after the sampled read strobe
  always @(posedge clk or negedge reset) begin
    if (!reset) rd_pend <= 1'b0;
    else        rd_pend <= re;
  end

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rdata_unexpected: act=0x%0h req=none", rdata);
      end else begin
        chk("rdata", {24'h0, rdata}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    addr = AW'(a); wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input int a, input logic [W-1:0] x);
    addr = AW'(a); re = 1'b1;
    exp_q.push_back(x);
    tick();
    re = 1'b0;
  endtask

  task automatic rw(input int a, input logic [W-1:0] d, input logic [W-1:0] x);
    addr = AW'(a); wdata = d; we = 1'b1; re = 1'b1;
    exp_q.push_back(x);
    tick();
    we = 1'b0; re = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    e = {4{8'h55}};
    repeat (3) tick();
    chk("reset_s", s, 32'h0);
    chk("reset_rdata", {24'h0, rdata}, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);

    // flags set 3 edges after release
    reset = 1'b1;
    rd(4, 8'h00);
    tick();
    rd(4, 8'h00);
    rd(4, 8'h0F);
    chk("release_irq", {31'h0, irq}, 32'h0);
    rw(4, 8'h0F, 8'h0F);
    rd(4, 8'h00);
    e = '0;
    repeat (4) tick();
    wr(4, 8'h0F);
    rd(4, 8'h00);

    // level output
    wr(2, 8'hA5);
    chk("level_s", s, 32'h00A5_0000);
    repeat (20) tick();
    chk("level_hold", s, 32'h00A5_0000);

    // input change, irq, read-clear
    wr(5, 8'h02);
    rd(5, 8'h02);
    e[15:8] = 8'h08;
    tick(); tick();
    chk("irq_early", {31'h0, irq}, 32'h0);
    tick();
    chk("irq_rise", {31'h0, irq}, 32'h1);
    rd(1, 8'h08);
    chk("irq_read_clear", {31'h0, irq}, 32'h0);
    tick();
    chk("rdata_hold", {24'h0, rdata}, 32'h08);
    rd(4, 8'h00);
    e[31:24] = 8'h80;
    repeat (3) tick();
    chk("irq_unmasked", {31'h0, irq}, 32'h0);
    rd(4, 8'h08);
    wr(4, 8'h08);
    rd(4, 8'h00);

    // set wins over W1C
    wr(5, 8'h03);
    e[7:0] = 8'h01;
    tick(); tick();
    wr(4, 8'h01);
    chk("setwin_irq", {31'h0, irq}, 32'h1);
    rd(4, 8'h01);
    wr(4, 8'h01);
    chk("w1c_irq", {31'h0, irq}, 32'h0);
    rd(4, 8'h00);

    // pulse mode
    wr(6, 8'h01);
    wr(0, 8'h05);
    chk("pulse_c0", {24'h0, s[7:0]}, 32'h05);
    tick(); chk("pulse_c1", {24'h0, s[7:0]}, 32'h05);
    tick(); chk("pulse_c2", {24'h0, s[7:0]}, 32'h05);
    tick(); chk("pulse_end", {24'h0, s[7:0]}, 32'h00);
    chk("pulse_other", {24'h0, s[23:16]}, 32'hA5);
    wr(0, 8'h05);
    tick();
    wr(0, 8'h0C);
    chk("reload_c0", {24'h0, s[7:0]}, 32'h0C);
    tick(); chk("reload_c1", {24'h0, s[7:0]}, 32'h0C);
    tick(); chk("reload_c2", {24'h0, s[7:0]}, 32'h0C);
    tick(); chk("reload_end", {24'h0, s[7:0]}, 32'h00);

    // mode cleared mid-pulse keeps the level
    wr(0, 8'h33);
    wr(6, 8'h00);
    repeat (5) tick();
    chk("mode_clear_hold", {24'h0, s[7:0]}, 32'h33);

    // async reset mid-pulse
    wr(6, 8'h01);
    wr(0, 8'h77);
    chk("pre_reset_s", {24'h0, s[7:0]}, 32'h77);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_s", s, 32'h0);
    chk("async_reset_irq", {31'h0, irq}, 32'h0);
    chk("async_reset_rdata", {24'h0, rdata}, 32'h0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("post_reset_s", s, 32'h0);

    // out-of-range access
    wr(7, 8'hFF);
    chk("oor_write_s", s, 32'h0);
    rd(7, 8'h00);
    rd(5, 8'h00);
    rd(6, 8'h00);
    rd(0, 8'h01);
    rd(2, 8'h00);

    tick(); tick();
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
